fifo_drain: RTL and testbench

//  Read-side controller for the synchronous FIFO. It issues rd_en only when the

---
 rtl/fifo_drain.sv | 67 ++++++
 tb/tb_fifo_drain.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// fifo_drain: FIFO read controller with 2-entry skid buffer, flush, word counter and sticky underflow flag
module fifo_drain #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_cnt,
  output logic                  underflow_err
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [1:0] occ_q, occ_d, occ_p;
  logic [2:0] lvl;
  logic infl_q, infl_d, err_q, err_d, pop, capture;
  logic [FIFO_WIDTH-1:0] s0_q, s0_d, s1_q, s1_d, s0_p;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  always_comb begin
    m_valid = occ_q != 2'd0 && state_q != FLUSH;
    pop = m_valid && m_ready;
    lvl = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop};
    fifo_rd_en = !fifo_empty && (state_q == FLUSH || (state_q == RUN && lvl < 3'd2));
    capture = infl_q && state_q != FLUSH && !flush;
    occ_p = occ_q - {1'b0, pop};
    s0_p = pop ? s1_q : s0_q;
    s0_d = capture && occ_p == 2'd0 ? fifo_dout : s0_p;
    s1_d = capture && occ_p == 2'd1 ? fifo_dout : s1_q;
    occ_d = flush ? 2'd0 : occ_p + {1'b0, capture};
    infl_d = fifo_rd_en;
    cnt_d = cnt_q + CNT_WIDTH'(pop);
    err_d = err_q || fifo_underflow;
    state_d = flush ? FLUSH :
              state_q == FLUSH ? ((fifo_empty && !infl_q && occ_q == 2'd0) ? IDLE : FLUSH) :
              enable ? RUN : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      occ_q <= '0;
      infl_q <= 1'b0;
      err_q <= 1'b0;
      s0_q <= '0;
      s1_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      occ_q <= occ_d;
      infl_q <= infl_d;
      err_q <= err_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
      cnt_q <= cnt_d;
    end
  end
  assign m_data = s0_q;
  assign rd_cnt = cnt_q;
  assign underflow_err = err_q;
endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: FIFO model plus scoreboard of expected words for fifo_drain
module tb_fifo_drain;
  localparam int W = 16;
  localparam int CW = 4;
  typedef struct {
    int n;
    int mode;
    int exp_cnt;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic flush = 1'b0;
  logic fifo_empty = 1'b1;
  logic fifo_underflow = 1'b0;
  logic m_ready = 1'b0;
  logic [W-1:0] fifo_dout = '0;
  logic fifo_rd_en, m_valid, underflow_err;
  logic [W-1:0] m_data;
  logic [CW-1:0] rd_cnt;
  int checks = 0;
  int errors = 0;
  int rd_pulses = 0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic stall = 1'b0;
  logic [W-1:0] stall_data = '0;
  vec_t vecs[5];

  fifo_drain #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .rd_cnt(rd_cnt), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(W'(base + i));
      exp_q.push_back(W'(base + i));
    end
  endtask

  // FIFO model: registered read data, combinational-style empty flag updated each edge
  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      rd_pulses++;
      chk("rd_en_when_empty", 32'(fifo_empty), 0);
      if (fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
    end
    fifo_empty <= fifo_q.size() == 0;
  end

  // Scoreboard consumer and stall-hold checker
  always @(negedge clk) begin
    if (!rst) begin
      if (stall) begin
        chk("hold_valid", 32'(m_valid), 1);
        chk("hold_data", 32'(m_data), 32'(stall_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got %0h want none", m_data);
        end else chk("order", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
    stall = !rst && !flush && m_valid && !m_ready;
    stall_data = m_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0] = '{5, 0, 8};
    vecs[1] = '{7, 1, 15};
    vecs[2] = '{6, 2, 5};
    vecs[3] = '{1, 0, 6};
    vecs[4] = '{3, 1, 9};
    step();
    load(1, 16'h55);
    step();
    step();
    mid();
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_cnt", 32'(rd_cnt), 0);
    chk("rst_err", 32'(underflow_err), 0);
    step();
    fifo_q.delete();
    exp_q.delete();
    rst = 1'b0;
    step();
    step();
    load(8, 1);
    step();
    enable = 1'b1;
    m_ready = 1'b1;
    step();
    mid();
    chk("lat_rd_en", 32'(fifo_rd_en), 1);
    chk("lat_valid_t0", 32'(m_valid), 0);
    step();
    mid();
    chk("lat_valid_t1", 32'(m_valid), 0);
    step();
    mid();
    chk("lat_valid_t2", 32'(m_valid), 1);
    chk("lat_data", 32'(m_data), 1);
    for (int i = 1; i < 8; i++) begin
      step();
      mid();
      chk("stream_gapless", 32'(m_valid), 1);
    end
    step();
    mid();
    chk("stream_cnt", 32'(rd_cnt), 8);
    chk("stream_rd_en_low", 32'(fifo_rd_en), 0);
    chk("stream_valid_low", 32'(m_valid), 0);
    step();
    enable = 1'b0;
    m_ready = 1'b0;
    load(8, 16'h11);
    step();
    rd_pulses = 0;
    enable = 1'b1;
    repeat (10) step();
    mid();
    chk("bp_pulses", 32'(rd_pulses), 2);
    chk("bp_valid", 32'(m_valid), 1);
    chk("bp_data", 32'(m_data), 16'h11);
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mid();
      chk("bp_gapless", 32'(m_valid), 1);
      step();
    end
    mid();
    chk("bp_cnt_wrap", 32'(rd_cnt), 0);
    chk("bp_valid_low", 32'(m_valid), 0);
    step();
    m_ready = 1'b0;
    load(7, 16'h21);
    repeat (8) step();
    mid();
    chk("fl_pre_valid", 32'(m_valid), 1);
    chk("fl_pre_data", 32'(m_data), 16'h21);
    chk("fl_pre_fifo", 32'(fifo_q.size()), 5);
    step();
    flush = 1'b1;
    enable = 1'b0;
    exp_q.delete();
    step();
    flush = 1'b0;
    m_ready = 1'b1;
    mid();
    chk("fl_valid", 32'(m_valid), 0);
    k = 0;
    while (fifo_q.size() != 0 && k < 30) begin
      step();
      k++;
    end
    repeat (3) step();
    mid();
    chk("fl_fifo_drained", 32'(fifo_q.size()), 0);
    chk("fl_valid_after", 32'(m_valid), 0);
    chk("fl_rd_en_after", 32'(fifo_rd_en), 0);
    chk("fl_cnt", 32'(rd_cnt), 0);
    step();
    load(3, 16'h31);
    step();
    enable = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      step();
      k++;
    end
    chk("fl_resume_done", 32'(k < 50), 1);
    enable = 1'b0;
    step();
    mid();
    chk("fl_resume_cnt", 32'(rd_cnt), 3);
    foreach (vecs[i]) begin
      step();
      m_ready = 1'b0;
      load(vecs[i].n, 16'h100 * (i + 1));
      step();
      enable = 1'b1;
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
        m_ready = vecs[i].mode == 0 ? 1'b1 : vecs[i].mode == 1 ? 1'($urandom_range(0, 1)) : k[0];
        step();
        k++;
      end
      chk("tbl_done", 32'(k < 200), 1);
      enable = 1'b0;
      step();
      mid();
      chk("tbl_cnt", 32'(rd_cnt), 32'(vecs[i].exp_cnt));
      chk("tbl_valid_low", 32'(m_valid), 0);
    end
    step();
    mid();
    chk("err_pre", 32'(underflow_err), 0);
    step();
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    mid();
    chk("err_set", 32'(underflow_err), 1);
    repeat (5) step();
    mid();
    chk("err_sticky", 32'(underflow_err), 1);
    step();
    m_ready = 1'b0;
    enable = 1'b1;
    load(4, 16'h41);
    k = 0;
    mid();
    while (fifo_rd_en !== 1'b1 && k < 10) begin
      step();
      mid();
      k++;
    end
    chk("mr_rd_seen", 32'(fifo_rd_en), 1);
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    fifo_q.delete();
    mid();
    chk("mr_rd_en", 32'(fifo_rd_en), 0);
    chk("mr_valid", 32'(m_valid), 0);
    chk("mr_data", 32'(m_data), 0);
    chk("mr_cnt", 32'(rd_cnt), 0);
    chk("mr_err", 32'(underflow_err), 0);
    step();
    rst = 1'b0;
    enable = 1'b0;
    m_ready = 1'b1;
    repeat (4) step();
    mid();
    chk("mr_no_ghost_valid", 32'(m_valid), 0);
    chk("mr_no_ghost_data", 32'(m_data), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
